// File: rtl/cpu_controller.sv
// ----------------------------------------------------------------------------
// cpu_controller
// Eight-phase sequencer for the 8-bit accumulator CPU. It decodes the 3-bit
// opcode and the ALU zero flag, then drives the per-phase strobes for the PC,
// IR, accumulator, memory and data bus. One instruction takes 8 cycles.
//
// Parameters
//   HALT_STICKY  1: HLT freezes the sequencer in phase 4 until reset
//                0: halt pulses for one cycle and sequencing continues
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous reset, active-high
//   i_opcode  IR[7:5]: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP
//   i_zero    ALU a_is_zero flag (only used in phase 6)
//   o_sel     address mux select: 1 = PC, 0 = IR operand field
//   o_rd      memory read enable
//   o_ld_ir   load instruction register
//   o_inc_pc  increment program counter
//   o_halt    CPU halted
//   o_ld_pc   load PC from IR operand
//   o_data_e  drive accumulator onto data bus
//   o_ld_ac   load accumulator from ALU result
//   o_wr      memory write strobe
//   o_phase   current phase 0..7
// ----------------------------------------------------------------------------
module cpu_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_opcode,
    input  logic       i_zero,
    output logic       o_sel,
    output logic       o_rd,
    output logic       o_ld_ir,
    output logic       o_inc_pc,
    output logic       o_halt,
    output logic       o_ld_pc,
    output logic       o_data_e,
    output logic       o_ld_ac,
    output logic       o_wr,
    output logic [2:0] o_phase
);

    typedef enum logic [2:0] {
        PhInstAddr  = 3'd0,
        PhInstFetch = 3'd1,
        PhInstLoad  = 3'd2,
        PhIdle      = 3'd3,
        PhOpAddr    = 3'd4,
        PhOpFetch   = 3'd5,
        PhAluOp     = 3'd6,
        PhStore     = 3'd7
    } phase_e;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    phase_e r_phase;
    phase_e w_phase_next;
    logic   r_halted;
    logic   w_halted_next;
    logic   w_aluop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase  <= PhInstAddr;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_next;
            r_halted <= w_halted_next;
        end
    end

    // Opcode is only consulted in phase 4, so an unknown opcode during fetch
    // cannot disturb the sequence.
    always_comb begin
        w_phase_next  = r_phase;
        w_halted_next = r_halted;
        if (!r_halted) begin
            unique case (r_phase)
                PhInstAddr:  w_phase_next = PhInstFetch;
                PhInstFetch: w_phase_next = PhInstLoad;
                PhInstLoad:  w_phase_next = PhIdle;
                PhIdle:      w_phase_next = PhOpAddr;
                PhOpAddr: begin
                    if (HALT_STICKY && (i_opcode == OpHlt)) begin
                        w_halted_next = 1'b1;
                    end else begin
                        w_phase_next = PhOpFetch;
                    end
                end
                PhOpFetch:   w_phase_next = PhAluOp;
                PhAluOp:     w_phase_next = PhStore;
                PhStore:     w_phase_next = PhInstAddr;
                default:     w_phase_next = PhInstAddr;
            endcase
        end
    end

    assign w_aluop = (i_opcode == OpAdd) || (i_opcode == OpAnd) ||
                     (i_opcode == OpXor) || (i_opcode == OpLda);

    // Reset overrides the decode combinationally so an instruction aborted in
    // phase 7 cannot emit wr or ld_ac during the reset cycle.
    always_comb begin
        o_sel    = 1'b0;
        o_rd     = 1'b0;
        o_ld_ir  = 1'b0;
        o_inc_pc = 1'b0;
        o_halt   = 1'b0;
        o_ld_pc  = 1'b0;
        o_data_e = 1'b0;
        o_ld_ac  = 1'b0;
        o_wr     = 1'b0;
        o_phase  = r_phase;
        if (i_rst) begin
            o_sel   = 1'b1;
            o_phase = PhInstAddr;
        end else if (r_halted) begin
            o_halt = 1'b1;
        end else begin
            unique case (r_phase)
                PhInstAddr: begin
                    o_sel = 1'b1;
                end
                PhInstFetch: begin
                    o_sel = 1'b1;
                    o_rd  = 1'b1;
                end
                PhInstLoad, PhIdle: begin
                    o_sel   = 1'b1;
                    o_rd    = 1'b1;
                    o_ld_ir = 1'b1;
                end
                PhOpAddr: begin
                    // First cycle of a halt still advances the PC once.
                    o_inc_pc = 1'b1;
                    o_halt   = (i_opcode == OpHlt);
                end
                PhOpFetch: begin
                    o_rd = w_aluop;
                end
                PhAluOp: begin
                    o_rd     = w_aluop;
                    o_inc_pc = (i_opcode == OpSkz) && i_zero;
                    o_ld_pc  = (i_opcode == OpJmp);
                    o_data_e = (i_opcode == OpSto);
                end
                PhStore: begin
                    o_rd     = w_aluop;
                    o_ld_ac  = w_aluop;
                    o_inc_pc = (i_opcode == OpJmp);
                    o_ld_pc  = (i_opcode == OpJmp);
                    o_data_e = (i_opcode == OpSto);
                    o_wr     = (i_opcode == OpSto);
                end
                default: begin
                    o_sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_controller
// Drives a sticky-halt and a non-sticky-halt controller with the same inputs
// and compares every output, packed as one vector, against a behavioural
// model built from the strobe table each cycle.
// ----------------------------------------------------------------------------
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;

    logic       sel0, rd0, ld_ir0, inc_pc0, halt0, ld_pc0, data_e0, ld_ac0, wr0;
    logic [2:0] phase0;
    logic       sel1, rd1, ld_ir1, inc_pc1, halt1, ld_pc1, data_e1, ld_ac1, wr1;
    logic [2:0] phase1;

    logic [11:0] obs0;
    logic [11:0] obs1;

    int n_checks;
    int n_pass;

    // Model state per instance: index 0 sticky, index 1 non-sticky.
    int m_ph    [2];
    bit m_halt  [2];

    cpu_controller #(.HALT_STICKY(1'b1)) u_dut_sticky (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_opcode (opcode),
        .i_zero   (zero),
        .o_sel    (sel0),
        .o_rd     (rd0),
        .o_ld_ir  (ld_ir0),
        .o_inc_pc (inc_pc0),
        .o_halt   (halt0),
        .o_ld_pc  (ld_pc0),
        .o_data_e (data_e0),
        .o_ld_ac  (ld_ac0),
        .o_wr     (wr0),
        .o_phase  (phase0)
    );

    cpu_controller #(.HALT_STICKY(1'b0)) u_dut_pulse (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_opcode (opcode),
        .i_zero   (zero),
        .o_sel    (sel1),
        .o_rd     (rd1),
        .o_ld_ir  (ld_ir1),
        .o_inc_pc (inc_pc1),
        .o_halt   (halt1),
        .o_ld_pc  (ld_pc1),
        .o_data_e (data_e1),
        .o_ld_ac  (ld_ac1),
        .o_wr     (wr1),
        .o_phase  (phase1)
    );

    assign obs0 = {sel0, rd0, ld_ir0, inc_pc0, halt0, ld_pc0, data_e0, ld_ac0, wr0, phase0};
    assign obs1 = {sel1, rd1, ld_ir1, inc_pc1, halt1, ld_pc1, data_e1, ld_ac1, wr1, phase1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr,phase[2:0]}.
    function automatic logic [11:0] exp_out(input int ph, input bit halted, input logic r,
                                            input logic [2:0] op, input logic z);
        bit aluop, e_sel, e_rd, e_ir, e_inc, e_halt, e_ldpc, e_de, e_ldac, e_wr;
        logic [2:0] e_ph;
        if (r) return {1'b1, 8'b0, 3'd0};
        e_ph = 3'(ph);
        if (halted) return {4'b0, 1'b1, 4'b0, e_ph};
        aluop  = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        e_sel  = (ph <= 3);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
        e_ir   = (ph == 2) || (ph == 3);
        e_inc  = (ph == 4) || (ph == 6 && op == SKZ && z == 1'b1) || (ph == 7 && op == JMP);
        e_halt = (ph == 4) && (op == HLT);
        e_ldpc = (ph >= 6) && (op == JMP);
        e_de   = (ph >= 6) && (op == STO);
        e_ldac = (ph == 7) && aluop;
        e_wr   = (ph == 7) && (op == STO);
        return {e_sel, e_rd, e_ir, e_inc, e_halt, e_ldpc, e_de, e_ldac, e_wr, e_ph};
    endfunction

    task automatic cycle(input logic r, input logic [2:0] op, input logic z, input string tag);
        logic [11:0] exp;
        logic [11:0] obs;
        @(negedge clk);
        rst    = r;
        opcode = op;
        zero   = z;
        #1;
        for (int s = 0; s < 2; s++) begin
            exp = exp_out(m_ph[s], m_halt[s], r, op, z);
            obs = (s == 0) ? obs0 : obs1;
            n_checks++;
            assert (obs === exp) n_pass++;
            else $error("FAIL %s inst=%0d observed=%b expected=%b", tag, s, obs, exp);
        end
        // Advance the model across the coming rising edge.
        for (int s = 0; s < 2; s++) begin
            if (r) begin
                m_ph[s]   = 0;
                m_halt[s] = 1'b0;
            end else if (m_halt[s]) begin
                m_ph[s] = m_ph[s];
            end else if (s == 0 && m_ph[s] == 4 && op == HLT) begin
                m_halt[s] = 1'b1;
            end else begin
                m_ph[s] = (m_ph[s] + 1) % 8;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ph[0] = 0; m_ph[1] = 0;
        m_halt[0] = 1'b0; m_halt[1] = 1'b0;
        rst = 1'b1; opcode = ADD; zero = 1'b0;

        cycle(1'b1, ADD, 1'b0, "reset");
        cycle(1'b1, ADD, 1'b0, "reset");

        // Unknown opcode during fetch phases must not disturb sequencing.
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'bxxx, 1'b0, "x_opcode");
        for (int i = 0; i < 4; i++) cycle(1'b0, ADD, 1'b0, "x_then_add");

        for (int i = 0; i < 9; i++) cycle(1'b0, ADD, 1'b0, "add");
        for (int i = 0; i < 7; i++) cycle(1'b0, SKZ, 1'b1, "skz_z1");
        for (int i = 0; i < 8; i++) cycle(1'b0, SKZ, 1'b0, "skz_z0");
        for (int i = 0; i < 8; i++) cycle(1'b0, STO, 1'b0, "sto");
        for (int i = 0; i < 8; i++) cycle(1'b0, JMP, 1'b0, "jmp");
        // Zero toggling outside phase 6 has no effect.
        for (int i = 0; i < 8; i++) cycle(1'b0, SKZ, 1'(i % 2), "skz_ztoggle");

        // Halt: sticky instance freezes in phase 4, the other keeps going.
        for (int i = 0; i < 30; i++) cycle(1'b0, HLT, 1'b0, "hlt");
        cycle(1'b1, ADD, 1'b0, "hlt_reset");
        cycle(1'b0, ADD, 1'b0, "after_hlt_reset");

        // Reset in phase 7 of a store.
        cycle(1'b1, STO, 1'b0, "sync_reset");
        for (int i = 0; i < 7; i++) cycle(1'b0, STO, 1'b0, "sto_pre");
        cycle(1'b1, STO, 1'b0, "sto_abort");
        cycle(1'b0, STO, 1'b0, "after_abort");

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
